// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the line memory arbiter.
// master = arbiter view, slave = caches + backing memory view.
interface mem_arbiter_if #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 10
);
  logic                 Ic_mem_req;
  logic [ADDR_BITS-1:0] Ic_mem_addr;
  logic [LINE_BITS-1:0] F_mem_inst;
  logic                 F_mem_valid;
  logic                 Dc_mem_req;
  logic [ADDR_BITS-1:0] Dc_mem_addr;
  logic [LINE_BITS-1:0] MEM_data_line;
  logic                 MEM_mem_valid;
  logic                 Dc_wb_we;
  logic [ADDR_BITS-1:0] Dc_wb_addr;
  logic [LINE_BITS-1:0] Dc_wb_wline;
  logic                 Dc_wb_busy;
  logic                 Arb_mem_req;
  logic                 Arb_mem_we;
  logic [ADDR_BITS-1:0] Arb_mem_addr;
  logic [LINE_BITS-1:0] Arb_mem_wline;
  logic [LINE_BITS-1:0] Arb_mem_rline;
  logic                 Arb_mem_valid;
  logic                 Arb_err;

  modport master (
    input  Ic_mem_req, Ic_mem_addr, Dc_mem_req, Dc_mem_addr,
           Dc_wb_we, Dc_wb_addr, Dc_wb_wline, Arb_mem_rline, Arb_mem_valid,
    output F_mem_inst, F_mem_valid, MEM_data_line, MEM_mem_valid, Dc_wb_busy,
           Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline, Arb_err
  );

  modport slave (
    output Ic_mem_req, Ic_mem_addr, Dc_mem_req, Dc_mem_addr,
           Dc_wb_we, Dc_wb_addr, Dc_wb_wline, Arb_mem_rline, Arb_mem_valid,
    input  F_mem_inst, F_mem_valid, MEM_data_line, MEM_mem_valid, Dc_wb_busy,
           Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline, Arb_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises I-cache reads, D-cache reads and buffered D-cache write-backs onto one line port.
// Optional ARB_RR_EN: round-robin I/D read arbitration; undefined gives fixed D-over-I priority.
module mem_arbiter #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 10,
  parameter int MAX_WAIT  = 15
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  localparam int WD_BITS = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_I, SRC_D, SRC_WB} src_t;

  typedef struct packed {
    src_t                 src;
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0] wline;
  } cmd_t;

  state_t               state, state_nx;
  cmd_t                 cmd_q, grant_cmd;
  logic                 grant;
  logic                 wbb_vld;
  logic [ADDR_BITS-1:0] wbb_addr;
  logic [LINE_BITS-1:0] wbb_line;
  logic [LINE_BITS-1:0] rline_q, f_line_q, d_line_q;
  logic [WD_BITS-1:0]   wd_cnt;
  logic                 err_q;
  logic                 wb_load, timeout, pick_d;
  logic                 f_pulse, d_pulse;

  assign wb_load = bus.Dc_wb_we & ~wbb_vld;
  assign timeout = (state == WAIT) && !bus.Arb_mem_valid &&
                   (wd_cnt == WD_BITS'(MAX_WAIT - 1));

`ifdef ARB_RR_EN
  logic last_d;

  assign pick_d = bus.Dc_mem_req & (~bus.Ic_mem_req | ~last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_d <= 1'b0;
    else if (state == IDLE && grant && grant_cmd.src != SRC_WB)
      last_d <= (grant_cmd.src == SRC_D);
  end
`else
  assign pick_d = bus.Dc_mem_req;
`endif

  // A strobe being captured this cycle blocks read grants, so a D read of the
  // same line can never overtake the write-back that is about to enter the buffer.
  always_comb begin
    grant           = 1'b0;
    grant_cmd.src   = SRC_I;
    grant_cmd.we    = 1'b0;
    grant_cmd.addr  = bus.Ic_mem_addr;
    grant_cmd.wline = '0;
    if (wbb_vld) begin
      grant           = 1'b1;
      grant_cmd.src   = SRC_WB;
      grant_cmd.we    = 1'b1;
      grant_cmd.addr  = wbb_addr;
      grant_cmd.wline = wbb_line;
    end else if (wb_load) begin
      grant = 1'b0;
    end else if (pick_d) begin
      grant          = 1'b1;
      grant_cmd.src  = SRC_D;
      grant_cmd.addr = bus.Dc_mem_addr;
    end else if (bus.Ic_mem_req) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (bus.Arb_mem_valid) state_nx = RESP;
               else if (timeout)      state_nx = IDLE;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.Arb_mem_req   = 1'b0;
    bus.Arb_mem_we    = 1'b0;
    bus.Arb_mem_addr  = '0;
    bus.Arb_mem_wline = '0;
    f_pulse           = 1'b0;
    d_pulse           = 1'b0;
    case (state)
      ISSUE: begin
        bus.Arb_mem_req   = 1'b1;
        bus.Arb_mem_we    = cmd_q.we;
        bus.Arb_mem_addr  = cmd_q.addr;
        bus.Arb_mem_wline = cmd_q.wline;
      end
      RESP: begin
        f_pulse = (cmd_q.src == SRC_I) && bus.Ic_mem_req;
        d_pulse = (cmd_q.src == SRC_D) && bus.Dc_mem_req;
      end
      default: ;
    endcase
  end

  assign bus.F_mem_valid   = f_pulse;
  assign bus.F_mem_inst    = f_pulse ? rline_q : f_line_q;
  assign bus.MEM_mem_valid = d_pulse;
  assign bus.MEM_data_line = d_pulse ? rline_q : d_line_q;
  assign bus.Dc_wb_busy    = wbb_vld;
  assign bus.Arb_err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q    <= '0;
      wd_cnt   <= '0;
      rline_q  <= '0;
      f_line_q <= '0;
      d_line_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && grant)               cmd_q    <= grant_cmd;
      if (state == ISSUE)                       wd_cnt   <= '0;
      else if (state == WAIT)                   wd_cnt   <= wd_cnt + 1'b1;
      if (state == WAIT && bus.Arb_mem_valid)   rline_q  <= bus.Arb_mem_rline;
      if (f_pulse)                              f_line_q <= rline_q;
      if (d_pulse)                              d_line_q <= rline_q;
      if (timeout)                              err_q    <= 1'b1;
    end
  end

  // The entry is only released at the end of RESP (or on timeout), so it is
  // still busy in that cycle and cannot be refilled in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbb_vld  <= 1'b0;
      wbb_addr <= '0;
      wbb_line <= '0;
    end else if (wb_load) begin
      wbb_vld  <= 1'b1;
      wbb_addr <= bus.Dc_wb_addr;
      wbb_line <= bus.Dc_wb_wline;
    end else if ((state == RESP || timeout) && cmd_q.src == SRC_WB) begin
      wbb_vld  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single reads plus sequences for write-back
// ordering, contention, dropped request, watchdog and reset mid-transaction.
module tb_mem_arbiter;
  typedef struct { bit is_d; logic [9:0] addr; int lat; logic [127:0] line; } vec_t;
  typedef struct { bit is_d; logic [127:0] line; int cyc; } pulse_t;
  typedef struct { int cyc; logic we; logic [9:0] addr; logic [127:0] wline; } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  mem_arbiter_if #(.LINE_BITS(128), .ADDR_BITS(10)) bus ();
  mem_arbiter #(.LINE_BITS(128), .ADDR_BITS(10), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] pat(input logic [9:0] a);
    if (a == 10'h005) return 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;
    return {32'hC0DE_0000 + 32'(a), 32'hFACE_0000 + 32'(a),
            32'h5A5A_0000 ^ 32'(a), 32'(a) * 32'd3};
  endfunction

  // backing memory: latency mem_lat, optional mute, forced stray valid
  int  mem_lat = 1;
  bit  mem_mute = 1'b0;
  int  force_req = 0;
  initial begin
    logic [127:0] wr_mem [int];
    logic [127:0] rd_data;
    bit pend;
    int cnt, force_seen;
    pend = 1'b0; cnt = 0; force_seen = 0; rd_data = '0;
    bus.Arb_mem_valid = 1'b0;
    bus.Arb_mem_rline = '0;
    forever begin
      @(negedge clk);
      bus.Arb_mem_valid = 1'b0;
      if (force_req != force_seen) begin
        force_seen = force_req;
        bus.Arb_mem_valid = 1'b1;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          if (!mem_mute) begin
            bus.Arb_mem_valid = 1'b1;
            bus.Arb_mem_rline = rd_data;
          end
        end
      end
      if (bus.Arb_mem_req) begin
        if (bus.Arb_mem_we) wr_mem[int'(bus.Arb_mem_addr)] = bus.Arb_mem_wline;
        rd_data = wr_mem.exists(int'(bus.Arb_mem_addr)) ? wr_mem[int'(bus.Arb_mem_addr)]
                                                        : pat(bus.Arb_mem_addr);
        pend = 1'b1;
        cnt  = mem_lat;
      end
    end
  end

  pulse_t got_q[$];
  cmd_t   cmd_q[$];
  initial forever begin
    @(negedge clk);
    if (bus.F_mem_valid)   got_q.push_back('{1'b0, bus.F_mem_inst, cyc});
    if (bus.MEM_mem_valid) got_q.push_back('{1'b1, bus.MEM_data_line, cyc});
    if (bus.Arb_mem_req)   cmd_q.push_back('{cyc, bus.Arb_mem_we, bus.Arb_mem_addr, bus.Arb_mem_wline});
  end

  pulse_t exp_q[$];
  int     rd_idx = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic sb_drain();
    pulse_t g, e;
    while (rd_idx < got_q.size()) begin
      g = got_q[rd_idx];
      rd_idx++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got pulse d=%0d line %h at cycle %0d, want none", g.is_d, g.line, g.cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_port", 128'(g.is_d), 128'(e.is_d));
        chk("sb_line", g.line, e.line);
        if (e.cyc >= 0) chk("sb_cycle", 128'(g.cyc), 128'(e.cyc));
      end
    end
  endtask

  task automatic wait_pulses(input int target, input string name);
    for (int t = 0; t < 80 && got_q.size() < target; t++) begin
      @(negedge clk); #1;
    end
    if (got_q.size() < target) begin
      n_chk++;
      $display("FAIL %s: got %0d pulses, want %0d (timeout)", name, got_q.size(), target);
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic set_req(input bit is_d, input bit v, input logic [9:0] a);
    if (is_d) begin bus.Dc_mem_req = v; bus.Dc_mem_addr = a; end
    else      begin bus.Ic_mem_req = v; bus.Ic_mem_addr = a; end
  endtask

  task automatic run_read(input vec_t v);
    int n, c0;
    @(posedge clk); #1;
    mem_lat = v.lat;
    set_req(v.is_d, 1'b1, v.addr);
    n  = cyc;
    c0 = cmd_q.size();
    exp_q.push_back('{v.is_d, v.line, n + 2 + v.lat});
    wait_pulses(got_q.size() + 1, "read_pulse");
    @(posedge clk); #1;
    set_req(v.is_d, 1'b0, v.addr);
    chk("cmd_count", 128'(cmd_q.size()), 128'(c0 + 1));
    if (cmd_q.size() > c0) begin
      chk("cmd_cycle", 128'(cmd_q[c0].cyc), 128'(n + 1));
      chk("cmd_addr", 128'(cmd_q[c0].addr), 128'(v.addr));
      chk("cmd_we", 128'(cmd_q[c0].we), 128'(0));
    end
    sb_drain();
  endtask

  vec_t vecs[5];

  initial begin
    int n, c0, g0, dcount;
    logic [127:0] aa;
    aa = {32{4'hA}};
    vecs[0] = '{1'b0, 10'h005, 3, 128'hDEAD_0000_0000_0000_0000_0000_0000_0001};
    vecs[1] = '{1'b1, 10'h123, 1, pat(10'h123)};
    vecs[2] = '{1'b0, 10'h3FF, 2, pat(10'h3FF)};
    vecs[3] = '{1'b1, 10'h000, 6, pat(10'h000)};
    vecs[4] = '{1'b0, 10'h200, 1, pat(10'h200)};

    bus.Ic_mem_req = 0; bus.Ic_mem_addr = '0;
    bus.Dc_mem_req = 0; bus.Dc_mem_addr = '0;
    bus.Dc_wb_we = 0; bus.Dc_wb_addr = '0; bus.Dc_wb_wline = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_f_valid", 128'(bus.F_mem_valid), 0);
    chk("rst_f_inst", bus.F_mem_inst, 0);
    chk("rst_d_valid", 128'(bus.MEM_mem_valid), 0);
    chk("rst_d_line", bus.MEM_data_line, 0);
    chk("rst_wb_busy", 128'(bus.Dc_wb_busy), 0);
    chk("rst_mem_req", 128'(bus.Arb_mem_req), 0);
    chk("rst_mem_we", 128'(bus.Arb_mem_we), 0);
    chk("rst_mem_addr", 128'(bus.Arb_mem_addr), 0);
    chk("rst_mem_wline", bus.Arb_mem_wline, 0);
    chk("rst_err", 128'(bus.Arb_err), 0);
    rst = 1'b1;

    foreach (vecs[i]) run_read(vecs[i]);

    // write-back strobe and D read of the same line in the same cycle
    @(posedge clk); #1;
    mem_lat = 2;
    bus.Dc_wb_we = 1; bus.Dc_wb_addr = 10'h010; bus.Dc_wb_wline = aa;
    set_req(1'b1, 1'b1, 10'h010);
    n = cyc; c0 = cmd_q.size(); g0 = got_q.size();
    exp_q.push_back('{1'b1, aa, -1});
    @(posedge clk); #1;
    bus.Dc_wb_we = 0;
    @(negedge clk);
    chk("wb_busy_set", 128'(bus.Dc_wb_busy), 1);
    wait_pulses(g0 + 1, "wb_read_pulse");
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 10'h010);
    repeat (6) @(posedge clk);
    #1;
    dcount = 0;
    for (int i = g0; i < got_q.size(); i++) if (got_q[i].is_d) dcount++;
    chk("wb_d_pulses", 128'(dcount), 1);
    chk("wb_cmd_count", 128'(cmd_q.size()), 128'(c0 + 2));
    if (cmd_q.size() >= c0 + 2) begin
      chk("wb_first_we", 128'(cmd_q[c0].we), 1);
      chk("wb_first_cycle", 128'(cmd_q[c0].cyc), 128'(n + 2));
      chk("wb_first_addr", 128'(cmd_q[c0].addr), 128'h010);
      chk("wb_first_wline", cmd_q[c0].wline, aa);
      chk("wb_second_we", 128'(cmd_q[c0 + 1].we), 0);
      chk("wb_second_addr", 128'(cmd_q[c0 + 1].addr), 128'h010);
    end
    chk("wb_busy_clear", 128'(bus.Dc_wb_busy), 0);
    sb_drain();

    // I and D contention, both held
    @(posedge clk); #1;
    mem_lat = 2;
    g0 = got_q.size();
    set_req(1'b0, 1'b1, 10'h020);
    set_req(1'b1, 1'b1, 10'h030);
`ifdef ARB_RR_EN
    exp_q.push_back('{1'b1, pat(10'h030), -1});
    exp_q.push_back('{1'b0, pat(10'h020), -1});
    exp_q.push_back('{1'b1, pat(10'h030), -1});
`else
    exp_q.push_back('{1'b1, pat(10'h030), -1});
    exp_q.push_back('{1'b1, pat(10'h030), -1});
    exp_q.push_back('{1'b1, pat(10'h030), -1});
`endif
    wait_pulses(g0 + 3, "contention_pulses");
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 10'h030);
    exp_q.push_back('{1'b0, pat(10'h020), -1});
    wait_pulses(g0 + 4, "contention_i_pulse");
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 10'h020);
    sb_drain();

    // I request dropped during WAIT: transaction completes silently
    @(posedge clk); #1;
    mem_lat = 4;
    set_req(1'b0, 1'b1, 10'h040);
    n = cyc; c0 = cmd_q.size(); g0 = got_q.size();
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 10'h040);
    at_cyc(n + 10);
    chk("drop_no_pulse", 128'(got_q.size()), 128'(g0));
    chk("drop_cmd_count", 128'(cmd_q.size()), 128'(c0 + 1));
    sb_drain();

    // watchdog: memory never answers
    @(posedge clk); #1;
    mem_mute = 1'b1;
    set_req(1'b0, 1'b1, 10'h050);
    n = cyc; g0 = got_q.size();
    at_cyc(n + 10);
    set_req(1'b0, 1'b0, 10'h050);
    at_cyc(n + 16);
    chk("wd_err_before", 128'(bus.Arb_err), 0);
    at_cyc(n + 17);
    chk("wd_err_set", 128'(bus.Arb_err), 1);
    @(posedge clk); #1;
    force_req++;
    repeat (5) @(posedge clk);
    #1;
    chk("wd_no_pulse", 128'(got_q.size()), 128'(g0));
    chk("wd_err_sticky", 128'(bus.Arb_err), 1);
    sb_drain();
    mem_mute = 1'b0;
    run_read('{1'b1, 10'h0A5, 2, pat(10'h0A5)});

    // reset while a read waits and a write-back is buffered
    @(posedge clk); #1;
    mem_lat = 6;
    set_req(1'b0, 1'b1, 10'h060);
    n = cyc;
    at_cyc(n + 2);
    @(posedge clk); #1;
    bus.Dc_wb_we = 1; bus.Dc_wb_addr = 10'h070; bus.Dc_wb_wline = ~aa;
    @(posedge clk); #1;
    bus.Dc_wb_we = 0;
    @(negedge clk);
    chk("rmid_busy_before", 128'(bus.Dc_wb_busy), 1);
    rst = 1'b0;
    set_req(1'b0, 1'b0, 10'h060);
    #1;
    chk("rmid_busy", 128'(bus.Dc_wb_busy), 0);
    chk("rmid_err", 128'(bus.Arb_err), 0);
    chk("rmid_mem_req", 128'(bus.Arb_mem_req), 0);
    chk("rmid_f_inst", bus.F_mem_inst, 0);
    chk("rmid_d_line", bus.MEM_data_line, 0);
    chk("rmid_f_valid", 128'(bus.F_mem_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    c0 = cmd_q.size(); g0 = got_q.size();
    at_cyc(n + 14);
    chk("rmid_no_pulse", 128'(got_q.size()), 128'(g0));
    chk("rmid_no_cmd", 128'(cmd_q.size()), 128'(c0));
    sb_drain();
    chk("sb_leftover", 128'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
